// File: rtl/tile_speed_ctrl.sv
// Game-speed scheduler for the piano-tiles datapath: programmable tick
// generator that speeds up every LEVEL_HITS hits and runs the game FSM.
module tile_speed_ctrl #(
    parameter logic [31:0] DIV_INIT   = 32'd50_000_000,
    parameter logic [31:0] DIV_MIN    = 32'd5_000_000,
    parameter logic [31:0] DIV_STEP   = 32'd5_000_000,
    parameter int          LEVEL_HITS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        pause,
    input  logic        hit,
    input  logic        miss,
    output logic        tick,
    output logic        running,
    output logic        game_over,
    output logic [3:0]  level,
    output logic [31:0] cur_div
);

    localparam int HW = $clog2(LEVEL_HITS + 1);
    localparam logic [HW-1:0] HIT_LAST = HW'(LEVEL_HITS - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSED, OVER} state_t;

    state_t        state_q, state_d;
    logic [31:0]   cnt_q, cnt_d;
    logic [31:0]   div_q, div_d;
    logic [HW-1:0] hit_q, hit_d;
    logic [3:0]    lvl_q, lvl_d;
    logic          tick_q, tick_d;
    logic [32:0]   div_sub;
    logic          wrap;

    assign div_sub = {1'b0, div_q} - {1'b0, DIV_STEP};
    assign wrap    = (cnt_q == div_q - 32'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            div_q   <= DIV_INIT;
            hit_q   <= '0;
            lvl_q   <= '0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            hit_q   <= hit_d;
            lvl_q   <= lvl_d;
            tick_q  <= tick_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        hit_d   = hit_q;
        lvl_d   = lvl_q;
        unique case (state_q)
            IDLE, OVER: begin
                if (start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    hit_d   = '0;
                    lvl_d   = '0;
                    div_d   = DIV_INIT;
                end
            end
            RUN: begin
                cnt_d = wrap ? 32'd0 : cnt_q + 32'd1;
                if (miss) begin
                    state_d = OVER;
                end else if (pause) begin
                    state_d = PAUSED;
                end else if (hit) begin
                    if (hit_q == HIT_LAST) begin
                        hit_d = '0;
                        cnt_d = '0;
                        if (lvl_q != 4'd15)
                            lvl_d = lvl_q + 4'd1;
                        // 33-bit difference keeps the floor compare free of wrap
                        if (div_sub[32] || div_sub[31:0] < DIV_MIN)
                            div_d = DIV_MIN;
                        else
                            div_d = div_sub[31:0];
                    end else begin
                        hit_d = hit_q + 1'b1;
                    end
                end
            end
            PAUSED: begin
                if (miss)
                    state_d = OVER;
                else if (pause)
                    state_d = RUN;
            end
            default: state_d = IDLE;
        endcase
        // Look one cycle ahead so tick is registered yet lands on cnt==div-1.
        tick_d = (state_d == RUN) && (cnt_d == div_d - 32'd1);
    end

    assign tick      = tick_q;
    assign running   = (state_q == RUN);
    assign game_over = (state_q == OVER);
    assign level     = lvl_q;
    assign cur_div   = div_q;

endmodule
